i2c_eeprom_target: RTL and testbench
====================================

I2C_EEPROM_TARGET -- requirements
Module: i2c_eeprom_target

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h50, giving the 7-bit target address (8-bit write/read bytes 0xA0/0xA1).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops on scl_in and sda_in.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port scl_in, input, 1 bit: raw I2C SCL bus level.
REQ-006 Port sda_in, input, 1 bit: raw I2C SDA bus level.
REQ-007 Port sda_oe, output, 1 bit: open-drain pull-down enable; 1 drives SDA low, 0 releases it.
REQ-008 Port busy, output, 1 bit: high from an addressed START until the next STOP or NACK return to IDLE.
REQ-009 Port wp, input, 1 bit: write protect; present only when I2C_WP_EN is defined.

Function
REQ-010 The block SHALL hold 256x8 storage and an 8-bit word pointer; the pointer SHALL wrap 0xFF->0x00.
REQ-011 clk SHALL be at least 16x the SCL rate; scl/sda SHALL be sampled through SYNC_STAGES flops, with edges detected on the synchronized values.
REQ-012 START (SDA falls while SCL high) SHALL enter DEV_ADDR with bit count 7 from any state, including mid-byte (repeated START).
REQ-013 STOP (SDA rises while SCL high) SHALL enter IDLE from any state, release sda_oe and clear busy.
REQ-014 Incoming bits SHALL be sampled on SCL rising edges, MSB first.
REQ-015 sda_oe SHALL change only in the clk cycle after a detected SCL falling edge, never while SCL is high.
REQ-016 States SHALL be IDLE, DEV_ADDR, ACK_DEV, WORD_ADDR, ACK_WORD, WR_DATA, ACK_WR, RD_DATA, RD_ACK.
REQ-017 In DEV_ADDR, after 8 bits, if bits[7:1]==DEV_ADDR the block SHALL go to ACK_DEV, assert busy, and drive ACK (sda_oe=1) for the 9th clock.
REQ-018 In DEV_ADDR on address mismatch, the block SHALL leave sda_oe=0 and return to IDLE, ignoring traffic until the next START.
REQ-019 After ACK_DEV with R/W=0 the block SHALL go to WORD_ADDR; with R/W=1 it SHALL go to RD_DATA, driving mem[pointer] bit 7 at the ACK-ending SCL fall.
REQ-020 WORD_ADDR SHALL load the pointer with the received byte, then ACK via ACK_WORD, then go to WR_DATA.
REQ-021 WR_DATA SHALL receive a byte, write mem[pointer] in the cycle the 8th bit is sampled, increment the pointer, and ACK via ACK_WR, then return to WR_DATA.
REQ-022 In RD_DATA, sda_oe SHALL equal ~data_bit for each bit; after 8 bits the block SHALL release SDA and go to RD_ACK.
REQ-023 In RD_ACK, the master's bit SHALL be sampled on the SCL rise: ACK (0) increments the pointer and loads the next byte into RD_DATA; NACK (1) increments the pointer and goes to IDLE with sda_oe=0.
REQ-024 A STOP or START arriving before the 8th bit of a write byte SHALL discard the partial byte, leaving memory and the pointer unchanged.
REQ-025 A current-address read (START, 0xA1, no word address) SHALL read from the retained pointer.

Reset
REQ-026 On rst, the block SHALL set state=IDLE, sda_oe=0, busy=0, pointer=0x00, bit count=7, and synchronizers to 1 (idle bus).
REQ-027 rst mid-transaction SHALL abandon the transfer immediately; memory contents SHALL NOT be reset or altered.

Configuration
REQ-028 With I2C_WP_EN defined, the wp port SHALL exist; when wp=1 the block SHALL NACK (sda_oe=0) in ACK_WR, SHALL NOT write memory or increment the pointer, and SHALL go to IDLE; reads SHALL be unaffected.
REQ-029 Without I2C_WP_EN, the wp port SHALL be absent and writes SHALL always complete.

Verification
REQ-030 Byte write: START, 0xA0, 0x3C, 0x5A, STOP -> three ACKs, mem[0x3C]=0x5A, pointer=0x3D, busy low after STOP.
REQ-031 Random read: preload mem[0x10]=0xC3; START, 0xA0, 0x10, repeated START, 0xA1, read 1 byte, NACK, STOP -> byte 0xC3, pointer=0x11.
REQ-032 Wrap: START, 0xA0, 0xFE, 0x11, 0x22, 0x33, STOP -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33, pointer=0x01.
REQ-033 Address mismatch: START, 0xA4, 0x00, STOP -> sda_oe stays 0 throughout, busy stays 0, memory unchanged.
REQ-034 Abort: STOP after 4 data bits of 0x77 at pointer 0x20 -> mem[0x20] unchanged, state IDLE; rst mid-read -> sda_oe=0 the next cycle.
REQ-035 I2C_WP_EN with wp=1: START, 0xA0, 0x05, 0x99 -> data byte NACKed, mem[0x05] unchanged, state IDLE.

Source files
------------

// File: rtl/i2c_eeprom_target_if.sv
// I2C target pin bundle: raw SCL/SDA levels in, open-drain pull-down enable and busy out.
// The wp pin exists only when I2C_WP_EN is defined.
interface i2c_eeprom_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;
    logic busy;
`ifdef I2C_WP_EN
    logic wp;
    modport master (output scl_in, sda_in, wp, input sda_oe, busy);
    modport slave  (input scl_in, sda_in, wp, output sda_oe, busy);
`else
    modport master (output scl_in, sda_in, input sda_oe, busy);
    modport slave  (input scl_in, sda_in, output sda_oe, busy);
`endif
endinterface

// File: rtl/i2c_eeprom_target.sv
// 256x8 I2C EEPROM target with an auto-incrementing word pointer, oversampled by clk.
// Optional write protect: define I2C_WP_EN to add the wp pin (writes NACKed while wp=1).
module i2c_eeprom_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst,
    i2c_eeprom_target_if.slave bus
);
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_ACK_DEV   = 4'd2,
        ST_WORD_ADDR = 4'd3,
        ST_ACK_WORD  = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_ACK_WR    = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [7:0]             shreg, shreg_n, ptr, ptr_n;
    logic                   rw, rw_n, sda_oe, sda_oe_n, busy, busy_n;
    logic                   rx_step, byte_done, mem_we, wp_on;
    logic [7:0]             rx_byte, mem_rdata;
    logic [7:0]             mem [256];

`ifdef I2C_WP_EN
    assign wp_on = bus.wp;
`else
    assign wp_on = 1'b0;
`endif

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    assign rx_byte   = {shreg[6:0], sda_s};
    assign mem_rdata = mem[ptr];
    assign rx_step   = scl_rise && (state inside {ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA});
    assign byte_done = rx_step && (bit_cnt == 3'd0);
    assign bus.sda_oe = sda_oe;
    assign bus.busy   = busy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync[0] <= bus.scl_in;
            sda_sync[0] <= bus.sda_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync[i] <= scl_sync[i-1];
                sda_sync[i] <= sda_sync[i-1];
            end
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd7;
            shreg   <= 8'h00;
            ptr     <= 8'h00;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            ptr     <= ptr_n;
            rw      <= rw_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
        end
    end

    // NOTE: storage has no reset so its contents survive rst and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[ptr] <= rx_byte;
    end

    // In ACK states sda_oe doubles as the phase flag: first SCL fall drives ACK, second ends it.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ptr_n     = ptr;
        rw_n      = rw;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        mem_we    = 1'b0;
        if (stop_det) begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start_det) begin
            state_n   = ST_DEV_ADDR;
            bit_cnt_n = 3'd7;
            sda_oe_n  = 1'b0;
        end else begin
            // Receive shift; the 3-bit count wraps 0 -> 7 ready for the next byte.
            if (rx_step) begin
                shreg_n   = rx_byte;
                bit_cnt_n = bit_cnt - 3'd1;
            end
            case (state)
                ST_DEV_ADDR: if (byte_done) begin
                    if (rx_byte[7:1] == DEV_ADDR) begin
                        state_n = ST_ACK_DEV;
                        busy_n  = 1'b1;
                        rw_n    = rx_byte[0];
                    end else begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                    end
                end
                ST_WORD_ADDR: if (byte_done) begin
                    ptr_n   = rx_byte;
                    state_n = ST_ACK_WORD;
                end
                ST_WR_DATA: if (byte_done) begin
                    state_n = ST_ACK_WR;
                    if (!wp_on) begin
                        mem_we = 1'b1;
                        ptr_n  = ptr + 8'd1;
                    end
                end
                ST_ACK_DEV, ST_ACK_WORD, ST_ACK_WR: if (scl_fall) begin
                    if (state == ST_ACK_WR && wp_on) begin
                        state_n  = ST_IDLE;
                        sda_oe_n = 1'b0;
                        busy_n   = 1'b0;
                    end else if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else if (state == ST_ACK_DEV && rw) begin
                        state_n   = ST_RD_DATA;
                        sda_oe_n  = ~mem_rdata[7];
                        shreg_n   = {mem_rdata[6:0], 1'b0};
                        bit_cnt_n = 3'd7;
                    end else begin
                        sda_oe_n = 1'b0;
                        state_n  = (state == ST_ACK_DEV) ? ST_WORD_ADDR : ST_WR_DATA;
                    end
                end
                ST_RD_DATA: if (scl_fall) begin
                    sda_oe_n  = (bit_cnt == 3'd0) ? 1'b0 : ~shreg[7];
                    shreg_n   = {shreg[6:0], 1'b0};
                    bit_cnt_n = bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) state_n = ST_RD_ACK;
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ptr_n = ptr + 8'd1;
                        if (sda_s) begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                        end
                    end else if (scl_fall) begin
                        state_n   = ST_RD_DATA;
                        sda_oe_n  = ~mem_rdata[7];
                        shreg_n   = {mem_rdata[6:0], 1'b0};
                        bit_cnt_n = 3'd7;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench: bit-banged I2C master on a wired-AND SDA line driving i2c_eeprom_target.
module tb_i2c_eeprom_target;
    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst;
    logic sda_m;
    logic watch = 1'b0;
    logic seen_oe, seen_busy;
    logic ack;
    logic [7:0] rd;
    int checks = 0;
    int failures = 0;

    i2c_eeprom_target_if bus ();

    i2c_eeprom_target dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.sda_in = sda_m & ~bus.sda_oe;

    always @(negedge clk) begin
        if (!watch) begin
            seen_oe   = 1'b0;
            seen_busy = 1'b0;
        end else begin
            if (bus.sda_oe) seen_oe = 1'b1;
            if (bus.busy) seen_busy = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        bus.scl_in = 1'b1; q();
        sda_m = 1'b0; q();
        bus.scl_in = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        bus.scl_in = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic bit_xfer(input logic b, output logic line);
        sda_m = b; q();
        bus.scl_in = 1'b1; q();
        line = bus.sda_in; q();
        bus.scl_in = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        logic line;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], line);
        bit_xfer(1'b1, line);
        a = ~line;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic line;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, line);
            d[i] = line;
        end
        bit_xfer(nack, line);
    endtask

    task automatic byte_write(input logic [7:0] addr, input logic [7:0] data);
        logic a;
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(addr, a);
        write_byte(data, a);
        i2c_stop();
    endtask

    initial begin
        rst = 1'b1;
        sda_m = 1'b1;
        bus.scl_in = 1'b1;
`ifdef I2C_WP_EN
        bus.wp = 1'b0;
`endif
        repeat (5) @(negedge clk);
        check("rst_sda_oe", 16'(bus.sda_oe), 16'h0);
        check("rst_busy", 16'(bus.busy), 16'h0);
        check("rst_ptr", 16'(dut.ptr), 16'h00);
        check("rst_state", 16'(dut.state), 16'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Byte write 0x5A to 0x3C
        i2c_start();
        write_byte(8'hA0, ack); check("bw_ack_dev", 16'(ack), 16'h1);
        check("bw_busy", 16'(bus.busy), 16'h1);
        write_byte(8'h3C, ack); check("bw_ack_word", 16'(ack), 16'h1);
        write_byte(8'h5A, ack); check("bw_ack_data", 16'(ack), 16'h1);
        i2c_stop();
        check("bw_mem", 16'(dut.mem[8'h3C]), 16'h5A);
        check("bw_ptr", 16'(dut.ptr), 16'h3D);
        check("bw_busy_after_stop", 16'(bus.busy), 16'h0);

        // Random read of 0x10 after preloading 0xC3
        byte_write(8'h10, 8'hC3);
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h10, ack);
        i2c_start();
        write_byte(8'hA1, ack); check("rr_ack_dev", 16'(ack), 16'h1);
        read_byte(rd, 1'b1);
        i2c_stop();
        check("rr_data", 16'(rd), 16'hC3);
        check("rr_ptr", 16'(dut.ptr), 16'h11);

        // Pointer wrap on write
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'hFE, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        write_byte(8'h33, ack); check("wrap_ack_last", 16'(ack), 16'h1);
        i2c_stop();
        check("wrap_mem_fe", 16'(dut.mem[8'hFE]), 16'h11);
        check("wrap_mem_ff", 16'(dut.mem[8'hFF]), 16'h22);
        check("wrap_mem_00", 16'(dut.mem[8'h00]), 16'h33);
        check("wrap_ptr", 16'(dut.ptr), 16'h01);

        // Sequential read across the wrap
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'hFE, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        read_byte(rd, 1'b0); check("seq_rd0", 16'(rd), 16'h11);
        read_byte(rd, 1'b0); check("seq_rd1", 16'(rd), 16'h22);
        read_byte(rd, 1'b1); check("seq_rd2", 16'(rd), 16'h33);
        i2c_stop();
        check("seq_ptr", 16'(dut.ptr), 16'h01);

        // Current-address read from a pointer set by a word-address-only write
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'hFF, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, ack); check("cur_ack_dev", 16'(ack), 16'h1);
        read_byte(rd, 1'b1);
        i2c_stop();
        check("cur_data", 16'(rd), 16'h22);
        check("cur_ptr", 16'(dut.ptr), 16'h00);

        // Address mismatch
        watch = 1'b1;
        i2c_start();
        write_byte(8'hA4, ack); check("mm_ack_dev", 16'(ack), 16'h0);
        write_byte(8'h00, ack); check("mm_ack_word", 16'(ack), 16'h0);
        i2c_stop();
        @(negedge clk);
        check("mm_seen_oe", 16'(seen_oe), 16'h0);
        check("mm_seen_busy", 16'(seen_busy), 16'h0);
        watch = 1'b0;
        check("mm_mem_00", 16'(dut.mem[8'h00]), 16'h33);
        check("mm_ptr", 16'(dut.ptr), 16'h00);

        // Abort a write byte after 4 bits of 0x77
        byte_write(8'h20, 8'hE1);
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h20, ack);
        bit_xfer(1'b0, ack);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b1, ack);
        bit_xfer(1'b1, ack);
        i2c_stop();
        check("abort_mem", 16'(dut.mem[8'h20]), 16'hE1);
        check("abort_ptr", 16'(dut.ptr), 16'h20);
        check("abort_state", 16'(dut.state), 16'h0);

        // Reset while driving the first read bit of mem[0x00]=0x33
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        check("rstrd_driving", 16'(bus.sda_oe), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rstrd_sda_oe", 16'(bus.sda_oe), 16'h0);
        check("rstrd_state", 16'(dut.state), 16'h0);
        check("rstrd_busy", 16'(bus.busy), 16'h0);
        check("rstrd_ptr", 16'(dut.ptr), 16'h00);
        rst = 1'b0;
        sda_m = 1'b1;
        bus.scl_in = 1'b1;
        q();
        check("rstrd_mem_kept", 16'(dut.mem[8'h3C]), 16'h5A);

`ifdef I2C_WP_EN
        // Write protect: data byte NACKed, memory and pointer untouched
        byte_write(8'h05, 8'h4B);
        bus.wp = 1'b1;
        i2c_start();
        write_byte(8'hA0, ack); check("wp_ack_dev", 16'(ack), 16'h1);
        write_byte(8'h05, ack); check("wp_ack_word", 16'(ack), 16'h1);
        write_byte(8'h99, ack); check("wp_ack_data", 16'(ack), 16'h0);
        check("wp_state", 16'(dut.state), 16'h0);
        check("wp_mem", 16'(dut.mem[8'h05]), 16'h4B);
        check("wp_ptr", 16'(dut.ptr), 16'h05);
        i2c_stop();
        bus.wp = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
